// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer: stack pointer index, opcodes,
// FSM state encodings and the request legality check done at acceptance.
package stack_seq_pkg;

  localparam logic [1:0] SP_IDX = 2'd3;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH   = 3'd1,
    ST_POP_RD = 3'd2,
    ST_POP_WB = 3'd3,
    ST_POP_SP = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Overflow, underflow, or a pop that would clobber SP with stack data.
  function automatic logic req_error(input op_e        op,
                                     input logic [1:0] dst,
                                     input logic [7:0] depth,
                                     input logic [7:0] max_depth);
    if (op == OP_PUSH) return depth == max_depth;
    return (depth == 8'd0) || (dst == SP_IDX);
  endfunction

endpackage

// File: rtl/stack_seq.sv
// PUSH/POP micro-operation sequencer; owns the regfile ports and memory
// strobes while busy. Stack grows down: push stores at SP-1, pop loads from SP.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [1:0] req_reg,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] depth,
  output logic [1:0] rf_rd_addr1,
  input  logic [7:0] rf_rd_d1,
  output logic [1:0] rf_rd_addr2,
  input  logic [7:0] rf_rd_d2,
  output logic       rf_wr_en,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_d,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);

  localparam logic [7:0] MAX_DEPTH = 8'(STACK_DEPTH);

  state_e     state_q, state_d;
  logic [1:0] reg_q;
  logic [7:0] depth_q;
  logic [7:0] sp_dec, sp_inc;
  logic       accept;

  assign busy        = (state_q != ST_IDLE);
  assign req_ready   = !busy;
  assign accept      = req_valid && req_ready;
  assign depth       = depth_q;
  assign rf_rd_addr1 = reg_q;
  assign rf_rd_addr2 = SP_IDX;
  // 8-bit wrap is intentional: SP=0x00 pushes to 0xFF, SP=0xFF pops to 0x00.
  assign sp_dec      = rf_rd_d2 - 8'd1;
  assign sp_inc      = rf_rd_d2 + 8'd1;

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      reg_q   <= 2'd0;
      depth_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) reg_q <= req_reg;
      if (state_q == ST_PUSH)        depth_q <= depth_q + 8'd1;
      else if (state_q == ST_POP_SP) depth_q <= depth_q - 8'd1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_d    = state_q;
    done       = 1'b0;
    err        = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = 2'd0;
    rf_wr_d    = 8'd0;
    mem_addr   = 8'd0;
    mem_wdata  = 8'd0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_error(op_e'(req_op), req_reg, depth_q, MAX_DEPTH)) state_d = ST_ERR;
          else if (op_e'(req_op) == OP_PUSH)                          state_d = ST_PUSH;
          else                                                        state_d = ST_POP_RD;
        end
      end
      ST_PUSH: begin
        // Pushing r3 stores the pre-decrement SP since rf_rd_d1 is read before the write.
        mem_we     = 1'b1;
        mem_addr   = sp_dec;
        mem_wdata  = rf_rd_d1;
        rf_wr_en   = 1'b1;
        rf_wr_addr = SP_IDX;
        rf_wr_d    = sp_dec;
        done       = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_POP_RD: begin
        mem_re   = 1'b1;
        mem_addr = rf_rd_d2;
        state_d  = ST_POP_WB;
      end
      ST_POP_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = reg_q;
        rf_wr_d    = mem_rdata;
        state_d    = ST_POP_SP;
      end
      ST_POP_SP: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = SP_IDX;
        rf_wr_d    = sp_inc;
        done       = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
